fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter.sv | 112 +++++++++++
 tb/tb_fpu_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin issue arbiter, response router and flush control for a shared FPU
// Optional per-requester grant counters on grant_cnt_o when FPU_ARBITER_STATS_EN is defined.
module fpu_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int PAYLOAD_W = 64,
  parameter int RES_W     = 21,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [RES_W-1:0]             rsp_result_o,
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  output logic [PAYLOAD_W-1:0]         fpu_payload_o,
  output logic [1:0]                   fpu_tag_o,
  input  logic                         fpu_out_valid_i,
  output logic                         fpu_out_ready_o,
  input  logic [RES_W-1:0]             fpu_result_i,
  input  logic [1:0]                   fpu_tag_i,
  output logic                         fpu_flush_o,
  input  logic                         fpu_busy_i,
  input  logic                         flush_i,
`ifdef FPU_ARBITER_STATS_EN
  output logic [NUM_REQ*16-1:0]        grant_cnt_o,
`endif
  output logic                         tag_err_o
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  localparam logic [2:0] NR = 3'(NUM_REQ);
  localparam logic [0:0] RUN = 1'b0, FLUSH = 1'b1;

  logic [0:0]    state;
  logic [1:0]    ptr, gnt;
  logic [CW-1:0] cnt;
  logic          any, en, in_hs, out_hs, tag_ok, run;
  logic [3:0]    req_pad, rsp_pad, gnt_oh, vld_oh;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int i);
    return 2'((int'(p) + i) % NUM_REQ);
  endfunction

  assign req_pad = 4'(req_valid_i);
  assign rsp_pad = 4'(rsp_ready_i);

  // Scan from the farthest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_pad[rr_idx(ptr, i)]) begin
        gnt = rr_idx(ptr, i);
        any = 1'b1;
      end
    fpu_payload_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt == 2'(i)) fpu_payload_o = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
  end

  assign run            = state == RUN;
  assign en             = run && cnt != MAX_C;
  assign fpu_in_valid_o = en && any;
  assign in_hs          = fpu_in_valid_o && fpu_in_ready_i;
  assign gnt_oh         = 4'(fpu_in_valid_o && fpu_in_ready_i) << gnt;
  assign req_ready_o    = gnt_oh[NUM_REQ-1:0];
  assign fpu_tag_o      = gnt;

  // Out-of-range tags and anything seen during FLUSH are swallowed unconditionally.
  assign tag_ok          = {1'b0, fpu_tag_i} < NR;
  assign fpu_out_ready_o = (!run || !tag_ok) ? 1'b1 : rsp_pad[fpu_tag_i];
  assign vld_oh          = 4'(fpu_out_valid_i && run && tag_ok) << fpu_tag_i;
  assign rsp_valid_o     = vld_oh[NUM_REQ-1:0];
  assign rsp_result_o    = fpu_result_i;
  assign out_hs          = fpu_out_valid_i && fpu_out_ready_o && run;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      ptr         <= 2'd0;
      cnt         <= '0;
      tag_err_o   <= 1'b0;
      fpu_flush_o <= 1'b0;
    end else begin
      fpu_flush_o <= flush_i;
      if (fpu_out_valid_i && !tag_ok) tag_err_o <= 1'b1;
      if (in_hs) ptr <= (gnt == 2'(NUM_REQ - 1)) ? 2'd0 : gnt + 2'd1;
      if (flush_i) begin
        state <= FLUSH;
        cnt   <= '0;
      end else begin
        if (!run && !fpu_busy_i) state <= RUN;
        if (in_hs && !out_hs && cnt != MAX_C) cnt <= cnt + CW'(1);
        else if (!in_hs && out_hs && cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef FPU_ARBITER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) grant_cnt_o <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (in_hs && gnt == 2'(i) && grant_cnt_o[i*16 +: 16] != 16'hFFFF)
          grant_cnt_o[i*16 +: 16] <= grant_cnt_o[i*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed-vector bench for fpu_arbiter (NUM_REQ=2, MAX_OUTST=4)
module tb_fpu_arbiter;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [127:0] req_payload_i;
  logic [20:0]  rsp_result_o, fpu_result_i;
  logic         fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
  logic [63:0]  fpu_payload_o;
  logic [1:0]   fpu_tag_o, fpu_tag_i;
  logic         fpu_flush_o, fpu_busy_i, flush_i, tag_err_o;
`ifdef FPU_ARBITER_STATS_EN
  logic [31:0]  grant_cnt_o;
`endif
  int n_vec = 0, n_bad = 0;

  localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P1 = 64'hFEDC_BA98_7654_3210;

  fpu_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_payload_i(req_payload_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_payload_o(fpu_payload_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_tag_i(fpu_tag_i),
    .fpu_flush_o(fpu_flush_o), .fpu_busy_i(fpu_busy_i), .flush_i(flush_i),
`ifdef FPU_ARBITER_STATS_EN
    .grant_cnt_o(grant_cnt_o),
`endif
    .tag_err_o(tag_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 2'b00; rsp_ready_i = 2'b00; req_payload_i = {P1, P0};
    fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_tag_i = 2'd0;
    fpu_busy_i = 1'b0; flush_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_flush", 64'(fpu_flush_o), 64'd0);
    chk("rst_tag_err", 64'(tag_err_o), 64'd0);
    chk("rst_in_valid", 64'(fpu_in_valid_o), 64'd0);
    // round-robin issue until the outstanding limit is hit
    req_valid_i = 2'b11; fpu_in_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_tag", 64'(fpu_tag_o), 64'(k % 2));
      chk("rr_ready", 64'(req_ready_o), (k % 2) ? 64'd2 : 64'd1);
      chk("rr_payload", fpu_payload_o, (k % 2) ? P1 : P0);
      tick();
    end
    chk("full_ready", 64'(req_ready_o), 64'd0);
    chk("full_in_valid", 64'(fpu_in_valid_o), 64'd0);
    // one response brings the count to 3
    req_valid_i = 2'b00; fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 2'b01;
    fpu_result_i = 21'h1ABCD;
    #1;
    chk("rsp_valid0", 64'(rsp_valid_o), 64'd1);
    chk("rsp_ready0", 64'(fpu_out_ready_o), 64'd1);
    chk("rsp_result", 64'(rsp_result_o), 64'h1ABCD);
    tick();
    // simultaneous issue and response at 3 keeps 3
    req_valid_i = 2'b11; fpu_tag_i = 2'd1; rsp_ready_i = 2'b11;
    #1;
    chk("both_in_valid", 64'(fpu_in_valid_o), 64'd1);
    chk("both_tag", 64'(fpu_tag_o), 64'd0);
    tick();
    fpu_out_valid_i = 1'b0;
    #1;
    chk("at3_in_valid", 64'(fpu_in_valid_o), 64'd1);
    chk("at3_tag", 64'(fpu_tag_o), 64'd1);
    tick();
    chk("at4_ready", 64'(req_ready_o), 64'd0);
    // response stall on requester 1
    req_valid_i = 2'b00; fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; rsp_ready_i = 2'b01;
    #1;
    chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd2);
    chk("stall_ready", 64'(fpu_out_ready_o), 64'd0);
    tick();
    chk("stall_ready_hold", 64'(fpu_out_ready_o), 64'd0);
    rsp_ready_i = 2'b11;
    #1;
    chk("unstall_ready", 64'(fpu_out_ready_o), 64'd1);
    tick();
    fpu_out_valid_i = 1'b0; rsp_ready_i = 2'b00; req_valid_i = 2'b11;
    #1;
    chk("after_rsp_in_valid", 64'(fpu_in_valid_o), 64'd1);
    chk("after_rsp_tag", 64'(fpu_tag_o), 64'd0);
    tick();
    req_valid_i = 2'b00;
    // bad tag is dropped and latches tag_err_o
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd3;
    #1;
    chk("badtag_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("badtag_ready", 64'(fpu_out_ready_o), 64'd1);
    tick();
    fpu_out_valid_i = 1'b0; fpu_tag_i = 2'd0;
    #1;
    chk("tag_err_set", 64'(tag_err_o), 64'd1);
    tick(); tick(); tick();
    chk("tag_err_hold", 64'(tag_err_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("tag_err_clr", 64'(tag_err_o), 64'd0);
    // flush with two outstanding
    req_valid_i = 2'b01;
    tick(); tick();
    req_valid_i = 2'b00; fpu_busy_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; req_valid_i = 2'b11;
    #1;
    chk("flush_pulse", 64'(fpu_flush_o), 64'd1);
    chk("flush_block", 64'(fpu_in_valid_o), 64'd0);
    chk("flush_block_rdy", 64'(req_ready_o), 64'd0);
    tick();
    chk("flush_pulse_end", 64'(fpu_flush_o), 64'd0);
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("late_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("late_ready", 64'(fpu_out_ready_o), 64'd1);
      tick();
    end
    fpu_out_valid_i = 1'b0; fpu_busy_i = 1'b0;
    #1;
    chk("still_flush", 64'(fpu_in_valid_o), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("post_flush_issue", 64'(fpu_in_valid_o), 64'd1);
      tick();
    end
    chk("post_flush_full", 64'(fpu_in_valid_o), 64'd0);
`ifdef FPU_ARBITER_STATS_EN
    rst_i = 1'b1; req_valid_i = 2'b00;
    tick();
    rst_i = 1'b0;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 2'b11; req_valid_i = 2'b01;
    for (int k = 0; k < 5; k++) tick();
    req_valid_i = 2'b10;
    for (int k = 0; k < 2; k++) tick();
    req_valid_i = 2'b00; fpu_out_valid_i = 1'b0;
    #1;
    chk("grant_cnt", 64'(grant_cnt_o), 64'h0002_0005);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
